signed_divider: RTL and testbench

//  Sequential signed restoring divider, the inverse companion of the shift-add signed multiplier.

---
 rtl/signed_divider_pkg.sv | 19 +
 rtl/signed_divider_twos_complement.sv | 14 +
 rtl/signed_divider_unsigned_divider.sv | 67 ++++++
 rtl/signed_divider.sv | 137 +++++++++++++
 tb/tb_signed_divider.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/signed_divider_pkg.sv
// Shared arithmetic definitions for the signed divider: FSM state encoding
// and sign-magnitude helpers used alongside the shift-add multiplier.
package signed_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  // Sign-magnitude sign bit with negative zero suppressed.
  function automatic logic fix_sign(input logic neg, input logic nonzero);
    return neg & nonzero;
  endfunction

endpackage

// File: rtl/signed_divider_twos_complement.sv
// Operand magnitude conversion: absolute value of a two's complement word.
// Ports:
//   value  in   WIDTH  two's complement operand
//   mag_c  out  WIDTH  |value| as unsigned (most negative value maps to 2^(WIDTH-1))
module twos_complement #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] mag_c
);

  assign mag_c = value[WIDTH-1] ? WIDTH'(~value + WIDTH'(1)) : value;

endmodule

// File: rtl/signed_divider_unsigned_divider.sv
// Unsigned restoring divider datapath: rem/quo shift registers, trial
// subtractor and iteration counter. One quotient bit per step.
// Ports:
//   clk, rst_n  in        clock, synchronous active-low reset
//   load        in   1    capture operands, clear rem and cnt
//   dividend    in   W    unsigned dividend magnitude
//   divisor     in   W    unsigned divisor magnitude
//   step        in   1    perform one restoring iteration
//   quo         out  W    working quotient (holds dividend right after load)
//   rem         out  W    working remainder
//   last_c      out  1    the next step is the final one
module unsigned_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     rem_sh_c;
  logic [WIDTH:0]     trial_c;
  logic               borrow_c;

  // Shift {rem,quo} left by one, then trial-subtract the divisor; the extra
  // rem bit makes the borrow appear as the trial MSB.
  always_comb begin
    rem_sh_c = (WIDTH + 1)'({rem_q, quo_q[WIDTH-1]});
    trial_c  = rem_sh_c - {1'b0, dvs_q};
    borrow_c = trial_c[WIDTH];
  end

  // Working registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= borrow_c ? rem_sh_c : trial_c;
      quo_q <= {quo_q[WIDTH-2:0], ~borrow_c};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign quo    = quo_q;
  assign rem    = rem_q[WIDTH-1:0];
  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/signed_divider.sv
// Sequential signed restoring divider returning sign-magnitude quotient and
// remainder (truncating division). Companion of the shift-add multiplier.
// Ports:
//   clk, rst_n   in        clock, synchronous active-low reset
//   start        in   1    request, accepted only when idle
//   dividend     in   W    two's complement
//   divisor      in   W    two's complement
//   quotient     out  W    |dividend/divisor| truncated toward zero
//   q_sign       out  1    quotient sign (1 = negative, never for zero)
//   remainder    out  W    |remainder|
//   r_sign       out  1    remainder sign, follows dividend (never for zero)
//   busy         out  1    operation in flight, including the done cycle
//   done         out  1    one-cycle pulse, results valid from here on
//   div_by_zero  out  1    last result was a divide by zero
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             q_sign,
  output logic [WIDTH-1:0] remainder,
  output logic             r_sign,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] rem_w;
  logic             last_c;
  logic             accept_c;
  logic             step_c;
  logic             finish_c;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dbz_pend;
  logic [WIDTH-1:0] res_quo_c;
  logic [WIDTH-1:0] res_rem_c;

  twos_complement #(.WIDTH(WIDTH)) u_dvd_mag (.value(dividend), .mag_c(dvd_mag_c));
  twos_complement #(.WIDTH(WIDTH)) u_dvs_mag (.value(divisor),  .mag_c(dvs_mag_c));

  unsigned_divider #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_c),
    .dividend (dvd_mag_c),
    .divisor  (dvs_mag_c),
    .step     (step_c),
    .quo      (quo_w),
    .rem      (rem_w),
    .last_c   (last_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state. busy is still high in the done cycle, so a start there is ignored.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && !busy) state_next = (divisor == '0) ? ST_DONE : ST_ITER;
      ST_ITER: if (last_c) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      ST_IDLE: accept_c = start && !busy;
      ST_ITER: step_c   = 1'b1;
      ST_DONE: finish_c = 1'b1;
      default: ;
    endcase
  end

  // Operand signs and divide-by-zero flag for the operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
      dbz_pend <= 1'b0;
    end else if (accept_c) begin
      dvd_neg  <= (dividend[WIDTH-1] == SIGN_NEG);
      dvs_neg  <= (divisor[WIDTH-1] == SIGN_NEG);
      dbz_pend <= (divisor == '0);
    end
  end

  // On divide by zero the core still holds |dividend| in quo, which becomes the remainder.
  always_comb begin
    res_quo_c = dbz_pend ? '0    : quo_w;
    res_rem_c = dbz_pend ? quo_w : rem_w;
  end

  // Output registers; results hold until the next completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      q_sign      <= 1'b0;
      remainder   <= '0;
      r_sign      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE);
      done <= finish_c;
      if (finish_c) begin
        quotient    <= res_quo_c;
        remainder   <= res_rem_c;
        q_sign      <= fix_sign(dvd_neg ^ dvs_neg, res_quo_c != '0);
        r_sign      <= fix_sign(dvd_neg, res_rem_c != '0);
        div_by_zero <= dbz_pend;
      end
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: per-cycle comparison against an
// arithmetic reference model, plus directed cases with literal results.
module tb_signed_divider;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic         q_sign;
  logic [W-1:0] remainder;
  logic         r_sign;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  signed_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .q_sign      (q_sign),
    .remainder   (remainder),
    .r_sign      (r_sign),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer division, converted to sign-magnitude.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic qs,
                                  output logic [W-1:0] r, output logic rs,
                                  output logic dbz);
    int sa, sb, qi, ri;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      qi = 0; ri = sa; dbz = 1'b1;
    end else begin
      qi = sa / sb; ri = sa % sb; dbz = 1'b0;
    end
    q  = W'(qi < 0 ? -qi : qi);
    r  = W'(ri < 0 ? -ri : ri);
    qs = (qi < 0);
    rs = (ri < 0);
  endfunction

  // Model state: latency countdown for the operation in flight and the
  // expected value of every output in the following cycle.
  bit           model_ok = 1'b0;
  bit           inflight = 1'b0;
  bit           was_idle;
  int           left = 0;
  logic [W-1:0] p_q, p_r, exp_q, exp_r;
  logic         p_qs, p_rs, p_dbz, exp_qs, exp_rs, exp_dbz, exp_done, exp_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_ok = 1'b1;
      inflight = 1'b0;
      left     = 0;
      exp_q = '0; exp_r = '0; exp_qs = 1'b0; exp_rs = 1'b0;
      exp_dbz = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
    end else if (model_ok) begin
      was_idle = !inflight && !exp_done;
      exp_done = 1'b0;
      if (inflight) begin
        exp_busy = 1'b1;
        left--;
        if (left == 0) begin
          inflight = 1'b0;
          exp_q = p_q; exp_qs = p_qs; exp_r = p_r; exp_rs = p_rs; exp_dbz = p_dbz;
          exp_done = 1'b1;
        end
      end else begin
        exp_busy = 1'b0;
      end
      if (was_idle && start) begin
        ref_div(dividend, divisor, p_q, p_qs, p_r, p_rs, p_dbz);
        inflight = 1'b1;
        left     = (divisor == '0) ? 1 : int'(W) + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_done",      done,        exp_done);
      chk("cyc_busy",      busy,        exp_busy);
      chk("cyc_quotient",  quotient,    exp_q);
      chk("cyc_q_sign",    q_sign,      exp_qs);
      chk("cyc_remainder", remainder,   exp_r);
      chk("cyc_r_sign",    r_sign,      exp_rs);
      chk("cyc_dbz",       div_by_zero, exp_dbz);
    end
  end

  // Directed operation: called at a negedge, returns one cycle after done.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input int eq, input int eqs, input int er, input int ers, input int edbz);
    int n;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency",   n,           lat);
    chk("quotient",  quotient,    eq);
    chk("q_sign",    q_sign,      eqs);
    chk("remainder", remainder,   er);
    chk("r_sign",    r_sign,      ers);
    chk("dbz",       div_by_zero, edbz);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_signs"}, {q_sign, r_sign, div_by_zero}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_div(8'd100, 8'd7,   9, 14,  0, 2, 0, 0);
    do_div(8'd156, 8'd7,   9, 14,  1, 2, 1, 0);   // -100 / 7
    do_div(8'd100, 8'hF9,  9, 14,  1, 2, 0, 0);   // 100 / -7
    do_div(8'h80,  8'hFF,  9, 128, 0, 0, 0, 0);   // -128 / -1
    do_div(8'hFA,  8'd3,   9, 2,   1, 0, 0, 0);   // -6 / 3
    do_div(8'd0,   8'hFB,  9, 0,   0, 0, 0, 0);   // 0 / -5
    do_div(8'hF9,  8'd0,   1, 0,   0, 7, 1, 1);   // -7 / 0
    do_div(8'd9,   8'd3,   9, 3,   0, 0, 0, 0);
    do_div(8'h80,  8'd1,   9, 128, 1, 0, 0, 0);   // -128 / 1

    // Start while busy is ignored; previous result held meanwhile.
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 8'd99; divisor = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_quotient", quotient, 128);
    chk("hold_q_sign", q_sign, 1);
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("busy_start_quotient", quotient, 10);
    chk("busy_start_remainder", remainder, 0);
    // Start in the done cycle is ignored as well.
    dividend = 8'd99; divisor = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_cycle_start_busy", busy, 0);

    // Reset mid-operation discards the result.
    dividend = 8'd127; divisor = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    do_div(8'd20, 8'd6, 9, 3, 0, 2, 0, 0);

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       dividend = 8'h80;
        1:       dividend = 8'h7F;
        default: dividend = W'($urandom);
      endcase
      case ($urandom_range(0, 11))
        0:       divisor = '0;
        1:       divisor = 8'hFF;
        2:       divisor = 8'h80;
        default: divisor = W'($urandom);
      endcase
      rst_n = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
